// File: rtl/sync_filter_pkg.sv
// Shared constants for the gate-drive input conditioning path.
// The detector top reuses the default depths so both stay in step.
package sync_filter_pkg;

  localparam int SF_STAGES      = 2;
  localparam int SF_FILT_CYCLES = 4;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: flop-chain synchronizer, stability counter and registered
// level/edge/glitch outputs. Every output comes straight from a flop.
module sync_filter_ch
  import sync_filter_pkg::*;
#(
  parameter int   STAGES      = SF_STAGES,
  parameter int   FILT_CYCLES = SF_FILT_CYCLES,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic glitch
);

  localparam int CW = clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [STAGES-1:0] sync_q;
  logic [CW-1:0]     cnt;
  logic              s;

  // Plain shift register: nothing may sit between the metastability stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  assign s = sync_q[STAGES-1];

  // cnt counts consecutive edges that saw s differ from dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= RST_VAL;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
      if (s == dout) begin
        if (cnt != '0) begin
          cnt    <= '0;
          glitch <= 1'b1;
        end
      end else if (cnt == CNT_LAST) begin
        dout <= s;
        cnt  <= '0;
        rise <= s;
        fall <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sync_filter.sv
// WIDTH independent synchronize-and-debounce channels for the raw gate-drive
// and feedback pins ahead of shoot-through detection.
module sync_filter
  import sync_filter_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               STAGES      = SF_STAGES,
  parameter int               FILT_CYCLES = SF_FILT_CYCLES,
  parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] glitch
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_ch #(
      .STAGES      (STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .RST_VAL     (RST_VAL[i])
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (din[i]),
      .dout   (dout[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .glitch (glitch[i])
    );
  end

endmodule
